irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the peripherals (Timer0, Timer1, external sources) and the CP0 `HWInt[5:0]` input.
- Synchronises six raw interrupt lines and latches them as edge- or level-triggered pending bits.
- Applies a per-source enable and presents the masked request vector to CP0.
- Provides a claim/complete handshake so the exception handler services exactly one source at a time; it is selected by a fixed priority, with source 0 the highest.
- Sits on the Bridge at base 0x0000_7F20; its registers are selected by `Addr[3:2]`.

Parameters:
- NSRC, 6: number of interrupt sources. Must be ≤ 6 to fit `HWInt`.
- SYNC_STAGES, 2: flip-flop stages on each raw interrupt input. Minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- IrqIn  in  NSRC  raw interrupt lines from peripherals.
- Sel  in  1  Bridge chip-select for this block.
- Addr  in  32  byte address; only bits [3:2] are decoded.
- WE  in  1  write strobe, valid only when Sel=1.
- RE  in  1  read strobe, valid only when Sel=1. Triggers the claim side effect.
- WData  in  32  write data.
- RData  out  32  read data. Combinational from `Addr`, same cycle.
- HWInt  out  6  request vector to CP0. Bits at index NSRC and above are tied to 0.
- Busy  out  1  high while a claimed source is in service.

Behaviour:
- Registers (`Addr[3:2]`):
  - 0 ENABLE, RW, bits [NSRC-1:0].
  - 1 MODE, RW; bit = 1 means edge-triggered, 0 means level.
  - 2 PENDING: read returns the pending bits; write is write-1-to-clear and affects edge sources only.
  - 3 CLAIM/COMPLETE: a read claims; a write completes.
- Unused `RData` bits read 0.
- Reset (async): ENABLE=0, MODE=0, PENDING=0, synchroniser chains=0, edge-history=0, state=IDLE, `HWInt`=0, `Busy`=0.
- Input path: `IrqIn` passes through SYNC_STAGES flops to give `s`; the edge-history flop holds `s_d`.
  - A rising edge is `s & ~s_d`.
  - Latency from an `IrqIn` rise to the `PENDING` bit: SYNC_STAGES+1 cycles.
- PENDING[i] update each cycle:
  - Edge mode: set on a rising edge. Cleared by W1C or by a claim of i. If a set and a clear occur in the same cycle, set wins.
  - Level mode: PENDING[i] = `s[i]`, registered. W1C and claim have no effect.
- `req` = PENDING & ENABLE.
- `win` = the lowest index i with `req[i]=1`.
- State machine:
  - IDLE: `HWInt = req` (zero-extended to 6 bits); `Busy`=0.
    - A read of CLAIM (Sel & RE & Addr[3:2]=3) with `req` non-zero returns bit31=1 and bits[2:0]=`win`. On that clock edge: store `win` in `cur_id`, clear PENDING[win] if it is edge mode, go to SERVICING.
    - A CLAIM read with `req`=0 returns 0 and the state does not change.
  - SERVICING: `HWInt`=0; `Busy`=1. No nesting.
    - A CLAIM read returns 0 and has no side effect.
    - A CLAIM write with `WData[2:0]==cur_id` returns to IDLE on the next edge.
    - A CLAIM write with a mismatched id is ignored.
    - Pending bits continue to latch while in SERVICING.
- Writes to ENABLE and MODE take effect on the next cycle.
  - A MODE change from level to edge keeps the current PENDING value.
  - A MODE change from edge to level reloads PENDING from `s` on the next cycle.
- Disabling the source that is currently in service does not end service; only a COMPLETE does.
- Writes with `Sel`=0 are ignored. A simultaneous RE and WE on CLAIM performs only the write (complete).
- Reset asserted while in SERVICING returns the block to IDLE immediately (asynchronous).

Test Plan:
- Reset, then pulse IrqIn[2] for one cycle with MODE[2]=1 and ENABLE=0x3F → PENDING reads 0x04 after 3 cycles; HWInt=6'b000100.
- Edge sources 1 and 4 both pending, then read CLAIM → RData=0x8000_0001, Busy=1, HWInt=0, PENDING=0x10. Write CLAIM with 1 → IDLE, HWInt=0x10. The next claim returns 0x8000_0004.
- Level source 3 held high, then claim and complete → PENDING[3] stays 1. HWInt[3] reasserts the cycle after complete. W1C 0x08 has no effect until IrqIn[3] falls (then cleared after 3 cycles).
- Claim source 0, then write CLAIM with 5 → ignored, Busy stays 1. A second CLAIM read returns 0. Write 0 → Busy=0.
- In the same cycle, W1C of PENDING[2] coincides with a new rising edge on source 2 → PENDING[2]=1 afterwards.
- Assert reset mid-SERVICING with PENDING=0x3F → all outputs 0 and ENABLE=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl -- memory-mapped interrupt controller feeding CP0 HWInt[5:0].
//
// Raw interrupt lines are synchronised, latched as edge- or level-triggered
// pending bits, masked by a per-source enable and presented to CP0. A
// claim/complete handshake lets the handler service one source at a time,
// chosen by fixed priority (source 0 highest).
//
// Register map (Addr[3:2]):
//   0 ENABLE  RW  per-source enable
//   1 MODE    RW  1 = edge-triggered, 0 = level
//   2 PENDING R   pending bits; write-1-to-clear (edge sources only)
//   3 CLAIM   read claims the winning source, write completes it
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   IrqIn  in   raw interrupt lines [NSRC-1:0]
//   Sel    in   Bridge chip-select
//   Addr   in   byte address, only [3:2] decoded
//   WE     in   write strobe (qualified by Sel)
//   RE     in   read strobe (qualified by Sel), triggers claim
//   WData  in   write data
//   RData  out  read data, combinational from Addr
//   HWInt  out  request vector to CP0 (bits >= NSRC tied to 0)
//   Busy   out  high while a claimed source is in service
// ----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] IrqIn,
    input  logic            Sel,
    input  logic [31:0]     Addr,
    input  logic            WE,
    input  logic            RE,
    input  logic [31:0]     WData,
    output logic [31:0]     RData,
    output logic [5:0]      HWInt,
    output logic            Busy
);

    typedef enum logic {
        IDLE      = 1'b0,
        SERVICING = 1'b1
    } state_e;

    // Lowest set index of v (0 when v is empty; callers qualify with |v).
    function automatic logic [2:0] prio_enc(input logic [NSRC-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;
    logic [NSRC-1:0] hist_q;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [2:0]      cur_id_q, cur_id_d;
    state_e          state_q, state_d;

    logic [NSRC-1:0] s_s;
    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] req_s;
    logic [2:0]      win_s;
    logic [1:0]      reg_sel_s;
    logic            wr_s;
    logic            claim_rd_s;
    logic            claim_fire_s;
    logic            complete_s;
    logic [NSRC-1:0] clr_s;
    logic [31:0]     rdata_s;
    logic [5:0]      hwint_s;
    logic            unused_s;

    assign reg_sel_s = Addr[3:2];
    assign wr_s      = Sel & WE;
    // A simultaneous write wins over the read, so the claim needs ~WE.
    assign claim_rd_s   = Sel & RE & ~WE & (reg_sel_s == 2'd3);
    assign s_s          = sync_q[SYNC_STAGES-1];
    assign rise_s       = s_s & ~hist_q;
    assign req_s        = pending_q & enable_q;
    assign win_s        = prio_enc(req_s);
    assign claim_fire_s = claim_rd_s & (state_q == IDLE) & (|req_s);
    assign complete_s   = wr_s & (reg_sel_s == 2'd3) & (state_q == SERVICING)
                          & (WData[2:0] == cur_id_q);
    assign unused_s     = ^{Addr[31:4], Addr[1:0], WData[31:NSRC]};

    // Synchroniser shift chain: stage 0 samples the raw lines.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = IrqIn;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Edge-source clear requests from W1C and from a claim of the winner.
    always_comb begin
        clr_s = {NSRC{1'b0}};
        if (wr_s && (reg_sel_s == 2'd2)) begin
            clr_s = WData[NSRC-1:0];
        end else begin
            clr_s = {NSRC{1'b0}};
        end
        if (claim_fire_s) begin
            clr_s = clr_s | (NSRC'(1'b1) << win_s);
        end else begin
            clr_s = clr_s;
        end
    end

    // Pending update: edge sources set-wins-over-clear, level sources follow s.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i]) begin
                pending_d[i] = rise_s[i] | (pending_q[i] & ~clr_s[i]);
            end else begin
                pending_d[i] = s_s[i];
            end
        end
    end

    // ENABLE and MODE register writes.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr_s && (reg_sel_s == 2'd0)) begin
            enable_d = WData[NSRC-1:0];
        end else begin
            enable_d = enable_q;
        end
        if (wr_s && (reg_sel_s == 2'd1)) begin
            mode_d = WData[NSRC-1:0];
        end else begin
            mode_d = mode_q;
        end
    end

    // Claim/complete state machine: next state and captured id.
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (claim_fire_s) begin
                    state_d  = SERVICING;
                    cur_id_d = win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICING: begin
                // Only a matching COMPLETE ends service; disabling does not.
                if (complete_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read mux; CLAIM data is only non-zero when a claim would succeed.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_sel_s)
            2'd0: rdata_s[NSRC-1:0] = enable_q;
            2'd1: rdata_s[NSRC-1:0] = mode_q;
            2'd2: rdata_s[NSRC-1:0] = pending_q;
            2'd3: begin
                if ((state_q == IDLE) && (|req_s)) begin
                    rdata_s[31]  = 1'b1;
                    rdata_s[2:0] = win_s;
                end else begin
                    rdata_s = 32'd0;
                end
            end
            default: rdata_s = 32'd0;
        endcase
    end

    // CP0 request vector, masked off while a source is in service.
    always_comb begin
        hwint_s = 6'd0;
        if (state_q == IDLE) begin
            hwint_s[NSRC-1:0] = req_s;
        end else begin
            hwint_s = 6'd0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '{default: {NSRC{1'b0}}};
            hist_q    <= {NSRC{1'b0}};
            enable_q  <= {NSRC{1'b0}};
            mode_q    <= {NSRC{1'b0}};
            pending_q <= {NSRC{1'b0}};
            cur_id_q  <= 3'd0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= s_s;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            cur_id_q  <= cur_id_d;
            state_q   <= state_d;
        end
    end

    assign RData = rdata_s;
    assign HWInt = hwint_s;
    assign Busy  = (state_q == SERVICING);

endmodule

// File: tb/tb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for irq_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model built from a sample-delay line and per-source rules.
// ----------------------------------------------------------------------------
module tb_irq_ctrl;
    localparam int NSRC = 6;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  IrqIn;
    logic        Sel, WE, RE;
    logic [31:0] Addr, WData;
    logic [31:0] RData;
    logic [5:0]  HWInt;
    logic        Busy;

    irq_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .IrqIn(IrqIn), .Sel(Sel), .Addr(Addr),
        .WE(WE), .RE(RE), .WData(WData), .RData(RData), .HWInt(HWInt),
        .Busy(Busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] last_rd;

    // Model state
    logic [5:0] m_en, m_mode, m_pend;
    bit         m_busy;
    int         m_cur;
    logic [5:0] samp[$];   // samp[0] = IrqIn captured at most recent edge

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int m_win(input logic [5:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [5:0] m_hw();
        return m_busy ? 6'd0 : (m_pend & m_en);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        logic [5:0] req;
        req = m_pend & m_en;
        case (a)
            2'd0: return {26'd0, m_en};
            2'd1: return {26'd0, m_mode};
            2'd2: return {26'd0, m_pend};
            default: return (!m_busy && req != 6'd0) ? (32'h8000_0000 | 32'(m_win(req))) : 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_en = 6'd0; m_mode = 6'd0; m_pend = 6'd0; m_busy = 0; m_cur = 0;
        samp = {};
        for (int k = 0; k <= SYNC; k++) samp.push_back(6'd0);
    endtask

    // Advance the model across one rising edge using the inputs seen there.
    task automatic m_step();
        logic [5:0] sc, sp, rise, req;
        bit wrt, claim, compl;
        int w;
        logic [1:0] a;
        if (reset) begin
            m_reset();
        end else begin
            sc = samp[SYNC-1];
            sp = samp[SYNC];
            rise = sc & ~sp;
            req = m_pend & m_en;
            w = m_win(req);
            a = Addr[3:2];
            wrt = Sel && WE;
            claim = Sel && RE && !WE && a == 2'd3 && !m_busy && req != 6'd0;
            compl = wrt && a == 2'd3 && m_busy && (int'(WData[2:0]) == m_cur);
            for (int i = 0; i < NSRC; i++) begin
                if (m_mode[i]) begin
                    if (rise[i]) m_pend[i] = 1'b1;
                    else if ((wrt && a == 2'd2 && WData[i]) || (claim && w == i)) m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = sc[i];
                end
            end
            if (wrt && a == 2'd0) m_en = WData[5:0];
            if (wrt && a == 2'd1) m_mode = WData[5:0];
            if (claim) begin
                m_busy = 1; m_cur = w;
            end else if (compl) begin
                m_busy = 0;
            end
            samp.push_front(IrqIn);
            void'(samp.pop_back());
        end
    endtask

    // One clock cycle: compare outputs mid-low-phase, then step the model.
    task automatic cyc();
        #1;
        chk("cyc_hwint", {26'd0, HWInt}, {26'd0, m_hw()});
        chk("cyc_busy", {31'd0, Busy}, {31'd0, m_busy});
        last_rd = RData;
        if (Sel && RE && !WE) chk("cyc_rdata", RData, m_rdata(Addr[3:2]));
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        Sel = 1'b0; WE = 1'b0; RE = 1'b0; Addr = 32'd0; WData = 32'd0;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        Sel = 1'b1; WE = 1'b1; RE = 1'b0; Addr = 32'h7F20 | {28'd0, a, 2'b00}; WData = d;
        cyc();
        idle();
    endtask

    task automatic reg_rd(input logic [1:0] a);
        Sel = 1'b1; WE = 1'b0; RE = 1'b1; Addr = 32'h7F20 | {28'd0, a, 2'b00};
        cyc();
        idle();
    endtask

    task automatic peek(input string nm, input logic [5:0] hw, input logic b);
        #1;
        chk({nm, "_hwint"}, {26'd0, HWInt}, {26'd0, hw});
        chk({nm, "_busy"}, {31'd0, Busy}, {31'd0, b});
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        int r;
        reset = 1'b1; IrqIn = 6'd0; idle(); m_reset();
        @(negedge clk); @(negedge clk);
        peek("rst", 6'd0, 1'b0);
        Sel = 1'b1; Addr = 32'h7F20; #1 chk("rst_enable", RData, 32'd0);
        Addr = 32'h7F28; #1 chk("rst_pending", RData, 32'd0);
        idle();
        reset = 1'b0;

        // Edge pulse on source 2 reaches PENDING after three edges.
        reg_wr(2'd0, 32'h3F); reg_wr(2'd1, 32'h04);
        IrqIn = 6'h04; cyc(); IrqIn = 6'h00; cyc(); cyc();
        peek("edge2", 6'b000100, 1'b0);
        reg_rd(2'd2); chk("edge2_pending", last_rd, 32'h04);
        reg_wr(2'd2, 32'h04);

        // Two edge sources: priority, claim, complete, re-claim.
        reg_wr(2'd1, 32'h3F);
        IrqIn = 6'h12; cyc(); IrqIn = 6'h00; wait_cyc(2);
        reg_rd(2'd3); chk("claim1", last_rd, 32'h8000_0001);
        peek("svc1", 6'd0, 1'b1);
        reg_rd(2'd2); chk("svc1_pending", last_rd, 32'h10);
        reg_wr(2'd3, 32'd1);
        peek("done1", 6'h10, 1'b0);
        reg_rd(2'd3); chk("claim4", last_rd, 32'h8000_0004);
        reg_wr(2'd3, 32'd4);

        // Level source 3: claim does not clear, W1C has no effect.
        reg_wr(2'd1, 32'h37);
        IrqIn = 6'h08; wait_cyc(3);
        reg_rd(2'd3); chk("claim3", last_rd, 32'h8000_0003);
        reg_wr(2'd3, 32'd3);
        peek("lvl_reassert", 6'h08, 1'b0);
        reg_wr(2'd2, 32'h08);
        reg_rd(2'd2); chk("lvl_w1c", last_rd, 32'h08);
        IrqIn = 6'h00; wait_cyc(3);
        reg_rd(2'd2); chk("lvl_fall", last_rd, 32'h00);

        // Mismatched complete is ignored, no nested claim.
        reg_wr(2'd1, 32'h3F);
        IrqIn = 6'h01; cyc(); IrqIn = 6'h00; wait_cyc(2);
        reg_rd(2'd3); chk("claim0", last_rd, 32'h8000_0000);
        reg_wr(2'd3, 32'd5);
        peek("bad_done", 6'd0, 1'b1);
        reg_rd(2'd3); chk("nested_claim", last_rd, 32'd0);
        reg_wr(2'd3, 32'd0);
        peek("done0", 6'd0, 1'b0);

        // Set wins over a coincident W1C.
        IrqIn = 6'h04; cyc(); IrqIn = 6'h00; wait_cyc(2);
        reg_rd(2'd2); chk("pend2_pre", last_rd, 32'h04);
        IrqIn = 6'h04; cyc(); IrqIn = 6'h00; cyc();
        reg_wr(2'd2, 32'h04);
        reg_rd(2'd2); chk("set_wins", last_rd, 32'h04);
        reg_wr(2'd2, 32'h04);

        // Async reset in SERVICING with all sources pending.
        reg_wr(2'd1, 32'h00);
        IrqIn = 6'h3F; wait_cyc(3);
        reg_rd(2'd3); chk("claim_all", last_rd, 32'h8000_0000);
        reg_rd(2'd2); chk("pend_all", last_rd, 32'h3F);
        peek("pre_rst", 6'd0, 1'b1);
        Sel = 1'b1; Addr = 32'h7F20; reset = 1'b1;
        #1;
        chk("async_hwint", {26'd0, HWInt}, 32'd0);
        chk("async_busy", {31'd0, Busy}, 32'd0);
        chk("async_enable", RData, 32'd0);
        Addr = 32'h7F28; #1 chk("async_pending", RData, 32'd0);
        idle(); IrqIn = 6'h00; m_reset();
        cyc();
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NSRC; i++)
                if ($urandom_range(7) == 0) IrqIn[i] = ~IrqIn[i];
            idle();
            r = int'($urandom_range(99));
            if (r >= 45) begin
                Sel   = (r >= 50);
                Addr  = $urandom;
                WData = $urandom;
                case ($urandom_range(5))
                    0, 1, 2: RE = 1'b1;
                    3, 4:    WE = 1'b1;
                    default: begin RE = 1'b1; WE = 1'b1; end
                endcase
                if (WE && Addr[3:2] == 2'd3 && $urandom_range(9) < 7)
                    WData[2:0] = 3'(m_cur);
            end
            if ($urandom_range(999) == 0) begin
                reset = 1'b1; m_reset();
                cyc();
                reset = 1'b0;
            end else begin
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
